// File: rtl/pad_cfg_sequencer_if.sv
// Request/response bus between the pad-control register slave and the pad
// configuration sequencer. Signal names follow the sequencer's port view.
interface pad_cfg_sequencer_if #(
  parameter int CFG_W  = 6,
  parameter int ADDR_W = 6
);
  logic              cfg_req_i;
  logic              cfg_we_i;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [CFG_W-1:0]  cfg_wdata_i;
  logic              cfg_gnt_o;
  logic              resp_valid_o;
  logic              resp_err_o;
  logic [CFG_W-1:0]  resp_rdata_o;
  logic              cfg_busy_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_gnt_o, resp_valid_o, resp_err_o, resp_rdata_o, cfg_busy_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cfg_gnt_o, resp_valid_o, resp_err_o, resp_rdata_o, cfg_busy_o
  );
endinterface

// File: rtl/pad_cfg_sequencer.sv
// Per-pad configuration word store with glitch-safe update sequencing:
// gate OE, settle, apply the new word, settle again, release the gate.
module pad_cfg_sequencer #(
  parameter int N_PADS        = 48,
  parameter int CFG_W         = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  pad_cfg_sequencer_if.slave             bus,
  output logic [N_PADS-1:0][CFG_W-1:0]   pad_cfg_o,
  output logic [N_PADS-1:0]              oe_gate_o
);

  localparam int ADDR_W = 6;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    APPLY,
    RELEASE
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [CFG_W-1:0]                wdata_q, wdata_d;
  logic [N_PADS-1:0][CFG_W-1:0]    padCfg_q, padCfg_d;
  logic [N_PADS-1:0]               oeGate_q, oeGate_d;
  logic                            respValid_q, respValid_d;
  logic                            respErr_q, respErr_d;
  logic [CFG_W-1:0]                respRdata_q, respRdata_d;
  logic                            busy_q, busy_d;
  logic                            gnt;

  logic                            addrInRange;
  logic [CFG_W-1:0]                curWord;
  logic [N_PADS-1:0]               reqOneHot;

  // Decode of the requested pad; out-of-range addresses see a zero word.
  always_comb begin
    addrInRange = (32'(bus.cfg_addr_i) < N_PADS);
    curWord     = '0;
    reqOneHot   = '0;
    for (int p = 0; p < N_PADS; p++) begin
      if (bus.cfg_addr_i == ADDR_W'(p)) begin
        curWord      = padCfg_q[p];
        reqOneHot[p] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    padCfg_d    = padCfg_q;
    oeGate_d    = oeGate_q;
    respValid_d = 1'b0;
    respErr_d   = 1'b0;
    respRdata_d = '0;
    gnt         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_req_i) begin
          gnt     = 1'b1;
          addr_d  = bus.cfg_addr_i;
          wdata_d = bus.cfg_wdata_i;
          if (!bus.cfg_we_i) begin
            respValid_d = 1'b1;
            respErr_d   = !addrInRange;
            respRdata_d = curWord;
          end else if (!addrInRange || (bus.cfg_wdata_i == curWord)) begin
            respValid_d = 1'b1;
            respErr_d   = !addrInRange;
          end else begin
            state_d  = QUIESCE;
            cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
            oeGate_d = reqOneHot;
          end
        end
      end

      QUIESCE: begin
        if (cnt_q == '0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // The new word lands on the same edge that enters RELEASE.
      APPLY: begin
        for (int p = 0; p < N_PADS; p++) begin
          if (addr_q == ADDR_W'(p)) begin
            padCfg_d[p] = wdata_q;
          end
        end
        state_d = RELEASE;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      end

      RELEASE: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          oeGate_d    = '0;
          respValid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        oeGate_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      padCfg_q    <= '0;
      oeGate_q    <= '0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      padCfg_q    <= padCfg_d;
      oeGate_q    <= oeGate_d;
      respValid_q <= respValid_d;
      respErr_q   <= respErr_d;
      respRdata_q <= respRdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_gnt_o    = gnt;
  assign bus.resp_valid_o = respValid_q;
  assign bus.resp_err_o   = respErr_q;
  assign bus.resp_rdata_o = respRdata_q;
  assign bus.cfg_busy_o   = busy_q;
  assign pad_cfg_o        = padCfg_q;
  assign oe_gate_o        = oeGate_q;

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed and randomized bench for pad_cfg_sequencer, checked against a
// transaction-level model of the pad word array and sequence timing.
module tb_pad_cfg_sequencer;

  localparam int N_PADS = 48;
  localparam int CFG_W  = 6;
  localparam int S      = 4;
  localparam int VEC_W  = N_PADS * CFG_W;
  localparam int SEQ_LAT = 2 * S + 2;

  logic                          clk;
  logic                          rstN;
  logic [N_PADS-1:0][CFG_W-1:0]  padCfg;
  logic [N_PADS-1:0]             oeGate;

  int checks   = 0;
  int failures = 0;
  logic [CFG_W-1:0] mdl [N_PADS];

  pad_cfg_sequencer_if #(.CFG_W(CFG_W), .ADDR_W(6)) bus ();

  pad_cfg_sequencer #(
    .N_PADS(N_PADS),
    .CFG_W(CFG_W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .bus(bus.slave),
    .pad_cfg_o(padCfg),
    .oe_gate_o(oeGate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [VEC_W-1:0] obs,
                             input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] modelVec();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int p = 0; p < N_PADS; p++) v[p*CFG_W +: CFG_W] = mdl[p];
    return v;
  endfunction

  task automatic modelReset();
    for (int p = 0; p < N_PADS; p++) mdl[p] = '0;
  endtask

  // Presents a request at a negedge and waits (bounded) for its grant cycle.
  task automatic startRequest(input logic we, input logic [5:0] addr,
                              input logic [CFG_W-1:0] wdata, output logic ok);
    int budget;
    @(negedge clk);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_we_i    = we;
    bus.cfg_addr_i  = addr;
    bus.cfg_wdata_i = wdata;
    #1;
    budget = 40;
    while (!bus.cfg_gnt_o && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    ok = bus.cfg_gnt_o;
    if (!ok) begin
      checkOutput("grant_timeout", VEC_W'(0), VEC_W'(1));
      bus.cfg_req_i = 1'b0;
    end
  endtask

  // One full transaction, with the expected timing derived from the model.
  task automatic applyStimulus(input logic we, input logic [5:0] addr,
                               input logic [CFG_W-1:0] wdata);
    logic             ok;
    logic             inRange;
    logic [CFG_W-1:0] oldWord;
    logic             change;
    int               lat;
    logic [N_PADS-1:0] oneHot;
    inRange = (int'(addr) < N_PADS);
    oldWord = inRange ? mdl[addr] : '0;
    change  = we && inRange && (wdata != oldWord);
    lat     = change ? SEQ_LAT : 1;
    oneHot  = inRange ? (N_PADS'(1) << addr) : '0;

    startRequest(we, addr, wdata, ok);
    if (!ok) return;
    @(posedge clk);
    #1 bus.cfg_req_i = 1'b0;

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        checkOutput("resp_early", VEC_W'(bus.resp_valid_o), VEC_W'(0));
        checkOutput("gate_seq", VEC_W'(oeGate), VEC_W'(oneHot));
        checkOutput("busy_seq", VEC_W'(bus.cfg_busy_o), VEC_W'(1));
        checkOutput("pad_word_seq", VEC_W'(padCfg[addr]),
                    VEC_W'((k >= S + 2) ? wdata : oldWord));
      end else begin
        checkOutput("resp_valid", VEC_W'(bus.resp_valid_o), VEC_W'(1));
        checkOutput("resp_err", VEC_W'(bus.resp_err_o), VEC_W'(!inRange));
        if (!we) checkOutput("resp_rdata", VEC_W'(bus.resp_rdata_o), VEC_W'(oldWord));
        checkOutput("gate_idle", VEC_W'(oeGate), VEC_W'(0));
        checkOutput("busy_idle", VEC_W'(bus.cfg_busy_o), VEC_W'(0));
      end
    end
    if (change) mdl[addr] = wdata;
    @(negedge clk);
    checkOutput("resp_pulse", VEC_W'(bus.resp_valid_o), VEC_W'(0));
    checkOutput("pad_array", padCfg, modelVec());
  endtask

  initial begin
    logic             ok;
    logic [5:0]       rAddr;
    logic             rWe;
    logic [CFG_W-1:0] rData;
    logic [CFG_W-1:0] newWord;

    bus.cfg_req_i   = 1'b0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = '0;
    bus.cfg_wdata_i = '0;
    rstN = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_pad", padCfg, VEC_W'(0));
    checkOutput("reset_gate", VEC_W'(oeGate), VEC_W'(0));
    checkOutput("reset_busy", VEC_W'(bus.cfg_busy_o), VEC_W'(0));
    checkOutput("reset_resp", VEC_W'({bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o}), VEC_W'(0));
    rstN = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b0, 6'd5, '0);
    applyStimulus(1'b1, 6'd7, 6'h2A);
    applyStimulus(1'b0, 6'd7, '0);
    applyStimulus(1'b1, 6'd7, 6'h2A);
    applyStimulus(1'b1, 6'd50, 6'h3F);
    applyStimulus(1'b0, 6'd63, '0);

    // Second request held across a running sequence.
    newWord = mdl[9] ^ 6'h15;
    startRequest(1'b1, 6'd9, newWord, ok);
    if (ok) begin
      @(posedge clk);
      #1;
      bus.cfg_we_i   = 1'b0;
      bus.cfg_addr_i = 6'd9;
      for (int k = 1; k <= SEQ_LAT; k++) begin
        @(negedge clk);
        #1;
        checkOutput("held_gnt", VEC_W'(bus.cfg_gnt_o), VEC_W'(k == SEQ_LAT));
        checkOutput("held_resp", VEC_W'(bus.resp_valid_o), VEC_W'(k == SEQ_LAT));
      end
      mdl[9] = newWord;
      @(posedge clk);
      #1 bus.cfg_req_i = 1'b0;
      @(negedge clk);
      checkOutput("held_read_valid", VEC_W'(bus.resp_valid_o), VEC_W'(1));
      checkOutput("held_read_rdata", VEC_W'(bus.resp_rdata_o), VEC_W'(newWord));
    end

    // Reset in the middle of a QUIESCE on pad 2.
    applyStimulus(1'b1, 6'd2, 6'h11);
    startRequest(1'b1, 6'd2, 6'h3C, ok);
    if (ok) begin
      @(posedge clk);
      #1 bus.cfg_req_i = 1'b0;
      for (int k = 1; k <= 3; k++) @(negedge clk);
      checkOutput("pre_reset_gate", VEC_W'(oeGate[2]), VEC_W'(1));
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("midseq_gate", VEC_W'(oeGate), VEC_W'(0));
      checkOutput("midseq_pad", padCfg, VEC_W'(0));
      checkOutput("midseq_busy", VEC_W'(bus.cfg_busy_o), VEC_W'(0));
      repeat (2) @(negedge clk);
      rstN = 1'b1;
    end
    applyStimulus(1'b1, 6'd2, 6'h05);
    applyStimulus(1'b0, 6'd2, '0);

    for (int i = 0; i < 40; i++) begin
      rAddr = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(48, 63))
                                          : 6'($urandom_range(0, 47));
      rWe   = ($urandom_range(0, 2) != 0);
      if ((int'(rAddr) < N_PADS) && ($urandom_range(0, 3) == 0)) rData = mdl[rAddr];
      else rData = CFG_W'($urandom_range(0, 63));
      applyStimulus(rWe, rAddr, rData);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
